// File: rtl/ifu_if.sv
// Instruction-memory bus between the fetch unit and the instruction memory.
// The fetch unit raises im_req with a stable im_addr; the memory answers with
// im_ack and the instruction word in the same cycle.
interface ifu_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    // Fetch-unit side: issues requests, receives data.
    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    // Memory side: receives requests, returns data.
    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit for the single-cycle MIPS datapath.
// Holds the PC, fetches one instruction per step over the im bus, presents the
// decode fields to the controller and computes the next PC when the execute
// side retires. A misaligned jr target stops fetching until reset.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    ifu_if.master       im,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        retire,
    input  logic [2:0]  npc_sel,
    input  logic [31:0] rs_data,
    output logic        fetch_err
);

    // Control states; 2'd3 is unreachable and recovers to FETCH.
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    // Next-PC select codes driven by the controller.
    localparam logic [2:0] NPC_SEQ    = 3'b000;
    localparam logic [2:0] NPC_JUMP   = 3'b001;
    localparam logic [2:0] NPC_BRANCH = 3'b011;
    localparam logic [2:0] NPC_JR     = 3'b100;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] npc;
    logic [31:0] branch_off;
    logic        npc_misaligned;
    logic        ack_take;
    logic        retire_take;

    // An ack only counts while fetching; a retire only counts while executing.
    assign ack_take    = (state == S_FETCH) && im.im_ack;
    assign retire_take = (state == S_EXEC) && retire;

    // Decode fields and link value are pure wiring off the held registers.
    assign op       = instr[31:26];
    assign funct    = instr[5:0];
    assign pc_plus4 = pc + 32'd4;

    // Bus outputs: the request is masked by reset so no fetch leaks out while
    // rst is asserted.
    assign im.im_req   = (state == S_FETCH) && !rst;
    assign im.im_addr  = pc;
    assign instr_valid = (state == S_EXEC);

    // Word-aligned, sign-extended branch displacement.
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Next-PC selection; unknown codes fall back to sequential.
    always_comb begin
        // NOTE: default assignment first so every path drives npc and no latch is inferred.
        npc = pc_plus4;
        unique case (npc_sel)
            NPC_JUMP:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            NPC_BRANCH: npc = pc_plus4 + branch_off;
            NPC_JR:     npc = rs_data;
            default:    npc = pc_plus4;
        endcase
    end

    // Only a jr can produce a target that is not word aligned.
    assign npc_misaligned = (npc[1:0] != 2'b00);

    // Next-state logic for the fetch/execute/halt sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (ack_take) state_next = S_EXEC;
            end
            S_EXEC: begin
                if (retire_take) state_next = npc_misaligned ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // State register; reset has priority over every other event.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // PC advances only on a retire with an aligned target.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (retire_take && !npc_misaligned) begin
            pc <= npc;
        end
    end

    // Instruction latch captures the word only on an accepted ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= 32'd0;
        end else if (ack_take) begin
            instr <= im.im_rdata;
        end
    end

    // Sticky error flag for a misaligned jr target, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err <= 1'b0;
        end else if (retire_take && npc_misaligned) begin
            fetch_err <= 1'b1;
        end
    end

endmodule
